rs_alu: RTL
===========

RS_ALU -- requirements
Module: rs_alu

Interface
REQ-001 Parameter: RS_SIZE, default 8, number of reservation-station entries.
REQ-002 Parameter: ROB_W, default 4, ROB index width (ROB_INDEX_RANGE).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 rdy  input  1  global enable; when low, entry state is held.
REQ-006 ISSUE_flag_in  input  1  issue request from decoder.
REQ-007 ISSUE_op_in  input  6  ALU/branch/JALR opcode.
REQ-008 ISSUE_Q1_pend_in / ISSUE_Q2_pend_in  input  1 each  operand awaits a ROB result.
REQ-009 ISSUE_Q1_in / ISSUE_Q2_in  input  ROB_W each  producer ROB index when pending.
REQ-010 ISSUE_V1_in / ISSUE_V2_in  input  32 each  operand value when not pending.
REQ-011 ISSUE_idx_in_ROB_in  input  ROB_W  destination ROB index.
REQ-012 ALU_CDB_flag_in, ALU_CDB_val_in, ALU_CDB_idx_in  input  1/32/ROB_W  ALU result broadcast.
REQ-013 LSB_CDB_flag_in, LSB_CDB_val_in, LSB_CDB_idx_in  input  1/32/ROB_W  load result broadcast.
REQ-014 flush_in  input  1  ROB rollback on mispredict.
REQ-015 full_out  output  1  combinational; high when all entries are busy.
REQ-016 ALU_flag_out, ALU_op_out, ALU_val1_out, ALU_val2_out, ALU_idx_in_ROB_out  output  1/6/32/32/ROB_W  registered dispatch to ALU.

Function
REQ-017 Each entry SHALL hold busy, op, V1, V2, Q1, Q2, pend1, pend2, rob_idx; an operand is ready when its pend bit is 0.
REQ-018 An issue SHALL be accepted when ISSUE_flag_in=1, full_out=0, rdy=1 and flush_in=0; otherwise it SHALL be ignored with no state change.
REQ-019 An accepted issue SHALL write the lowest-indexed non-busy entry and set busy.
REQ-020 At issue, a pending operand whose Q matches a same-cycle CDB broadcast SHALL be captured as ready with that CDB value.
REQ-021 Every busy entry with a pending operand matching an active CDB index SHALL capture the value and clear pend on that edge; both operands may match in one cycle.
REQ-022 If ALU and LSB CDBs carry the same index in one cycle, the ALU value SHALL be used.
REQ-023 Dispatch SHALL select the lowest-indexed busy entry with pend1=pend2=0, based on registered state at the start of the cycle.
REQ-024 On dispatch, the entry's busy SHALL clear and the ALU_* outputs SHALL load the entry's fields at the same edge.
REQ-025 ALU_flag_out SHALL be high for exactly one cycle per dispatch; at most one dispatch per cycle.
REQ-026 With no dispatch, ALU_flag_out SHALL be 0 and ALU_op/val1/val2/idx outputs SHALL be 0.
REQ-027 Latency: an operand woken by the CDB in cycle N SHALL dispatch no earlier than edge N+1; an issue with both operands ready in cycle N SHALL dispatch no earlier than edge N+1.
REQ-028 Issue and dispatch in the same cycle SHALL both take effect; a freed entry becomes visible to full_out only after the edge.
REQ-029 flush_in=1 with rdy=1 SHALL clear all busy bits and ALU_flag_out at that edge; same-cycle issue, capture and dispatch are discarded.
REQ-030 rdy=0 SHALL hold all entries; ALU_flag_out SHALL be 0 at that edge; no issue, capture or dispatch.
REQ-031 Flush priority: flush_in > dispatch/issue/capture.

Reset
REQ-032 rst=0 SHALL asynchronously clear all busy and pend bits.
REQ-033 rst=0 SHALL asynchronously zero all ALU_* outputs.
REQ-034 During reset, full_out SHALL be 0.
REQ-035 Reset asserted mid-operation SHALL discard all entries and in-flight dispatches without a partial output.

Verification
REQ-036 Issue ADD with V1=5, V2=7 and no pending operand at cycle 0 -> ALU_flag_out=1 at edge 1 with val1=5, val2=7 and the issued ROB idx; RS empty.
REQ-037 Issue with pend1=1, Q1=3; ALU CDB idx=3, val=0x10 in cycle 2 -> captured; dispatched at edge 3 with val1=0x10.
REQ-038 Issue with pend2=1, Q2=6 while the LSB CDB broadcasts idx 6, val 0xAB in the same cycle -> captured at issue; dispatched the next edge with val2=0xAB.
REQ-039 Fill 8 entries, all pending -> full_out=1 and a ninth issue is ignored; wake entries 2 and 5 together -> entry 2 dispatches first, then entry 5 on the following edge.
REQ-040 Four busy entries plus flush_in=1 with a simultaneous issue -> all entries are empty, ALU_flag_out=0 and the issue is dropped.
REQ-041 rdy=0 for 3 cycles with a ready entry -> no dispatch; dispatch occurs on the first edge with rdy=1; rst=0 mid-run -> all outputs are 0 immediately.

Source files
------------

// File: rtl/rs_alu.sv
// ALU reservation station: buffers issued ops until both operands arrive on a CDB,
// then dispatches the lowest-indexed ready entry to the ALU through registered outputs.
module rs_alu #(
  parameter int RS_SIZE = 8,
  parameter int ROB_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             ISSUE_flag_in,
  input  logic [5:0]       ISSUE_op_in,
  input  logic             ISSUE_Q1_pend_in,
  input  logic             ISSUE_Q2_pend_in,
  input  logic [ROB_W-1:0] ISSUE_Q1_in,
  input  logic [ROB_W-1:0] ISSUE_Q2_in,
  input  logic [31:0]      ISSUE_V1_in,
  input  logic [31:0]      ISSUE_V2_in,
  input  logic [ROB_W-1:0] ISSUE_idx_in_ROB_in,
  input  logic             ALU_CDB_flag_in,
  input  logic [31:0]      ALU_CDB_val_in,
  input  logic [ROB_W-1:0] ALU_CDB_idx_in,
  input  logic             LSB_CDB_flag_in,
  input  logic [31:0]      LSB_CDB_val_in,
  input  logic [ROB_W-1:0] LSB_CDB_idx_in,
  input  logic             flush_in,
  output logic             full_out,
  output logic             ALU_flag_out,
  output logic [5:0]       ALU_op_out,
  output logic [31:0]      ALU_val1_out,
  output logic [31:0]      ALU_val2_out,
  output logic [ROB_W-1:0] ALU_idx_in_ROB_out
);

  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  logic [RS_SIZE-1:0] busy_q, busy_d;
  logic [RS_SIZE-1:0] pend1_q, pend1_d;
  logic [RS_SIZE-1:0] pend2_q, pend2_d;
  logic [5:0]         op_q  [RS_SIZE];
  logic [31:0]        v1_q  [RS_SIZE];
  logic [31:0]        v2_q  [RS_SIZE];
  logic [ROB_W-1:0]   q1_q  [RS_SIZE];
  logic [ROB_W-1:0]   q2_q  [RS_SIZE];
  logic [ROB_W-1:0]   rob_q [RS_SIZE];

  logic [32:0]        res1 [RS_SIZE];
  logic [32:0]        res2 [RS_SIZE];
  logic [RS_SIZE-1:0] hit1, hit2;
  logic [32:0]        iss_res1, iss_res2;
  logic               iss_hit1, iss_hit2;
  logic [31:0]        iss_v1, iss_v2;
  logic               issue_en;
  logic [IDX_W-1:0]   issue_idx;
  logic               disp_found;
  logic [IDX_W-1:0]   disp_idx;

  // Returns {hit, value}; the ALU bus wins when both buses carry the same tag.
  function automatic logic [32:0] cdb_resolve(
    input logic [ROB_W-1:0] q,
    input logic alu_f, input logic [ROB_W-1:0] alu_i, input logic [31:0] alu_v,
    input logic lsb_f, input logic [ROB_W-1:0] lsb_i, input logic [31:0] lsb_v
  );
    logic [32:0] r;
    r = '0;
    if (alu_f && alu_i == q)      r = {1'b1, alu_v};
    else if (lsb_f && lsb_i == q) r = {1'b1, lsb_v};
    return r;
  endfunction

  assign full_out = &busy_q;
  assign issue_en = ISSUE_flag_in && !full_out && rdy && !flush_in;

  always_comb begin
    iss_res1 = cdb_resolve(ISSUE_Q1_in, ALU_CDB_flag_in, ALU_CDB_idx_in, ALU_CDB_val_in,
                           LSB_CDB_flag_in, LSB_CDB_idx_in, LSB_CDB_val_in);
    iss_res2 = cdb_resolve(ISSUE_Q2_in, ALU_CDB_flag_in, ALU_CDB_idx_in, ALU_CDB_val_in,
                           LSB_CDB_flag_in, LSB_CDB_idx_in, LSB_CDB_val_in);
    iss_hit1 = ISSUE_Q1_pend_in && iss_res1[32];
    iss_hit2 = ISSUE_Q2_pend_in && iss_res2[32];
    iss_v1   = iss_hit1 ? iss_res1[31:0] : ISSUE_V1_in;
    iss_v2   = iss_hit2 ? iss_res2[31:0] : ISSUE_V2_in;
    for (int i = 0; i < RS_SIZE; i++) begin
      res1[i] = cdb_resolve(q1_q[i], ALU_CDB_flag_in, ALU_CDB_idx_in, ALU_CDB_val_in,
                            LSB_CDB_flag_in, LSB_CDB_idx_in, LSB_CDB_val_in);
      res2[i] = cdb_resolve(q2_q[i], ALU_CDB_flag_in, ALU_CDB_idx_in, ALU_CDB_val_in,
                            LSB_CDB_flag_in, LSB_CDB_idx_in, LSB_CDB_val_in);
      hit1[i] = pend1_q[i] && res1[i][32];
      hit2[i] = pend2_q[i] && res2[i][32];
    end
  end

  // Descending scan so the last assignment is the lowest matching index.
  always_comb begin
    issue_idx  = '0;
    disp_found = 1'b0;
    disp_idx   = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy_q[i]) issue_idx = IDX_W'(i);
      if (busy_q[i] && !pend1_q[i] && !pend2_q[i]) begin
        disp_found = 1'b1;
        disp_idx   = IDX_W'(i);
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    busy_d  = busy_q;
    pend1_d = pend1_q & ~hit1;
    pend2_d = pend2_q & ~hit2;
    if (disp_found) busy_d[disp_idx] = 1'b0;
    if (issue_en) begin
      busy_d[issue_idx]  = 1'b1;
      pend1_d[issue_idx] = ISSUE_Q1_pend_in && !iss_hit1;
      pend2_d[issue_idx] = ISSUE_Q2_pend_in && !iss_hit2;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q             <= '0;
      pend1_q            <= '0;
      pend2_q            <= '0;
      ALU_flag_out       <= 1'b0;
      ALU_op_out         <= '0;
      ALU_val1_out       <= '0;
      ALU_val2_out       <= '0;
      ALU_idx_in_ROB_out <= '0;
    end else if (!rdy || flush_in) begin
      if (rdy) begin
        busy_q  <= '0;
        pend1_q <= '0;
        pend2_q <= '0;
      end
      ALU_flag_out       <= 1'b0;
      ALU_op_out         <= '0;
      ALU_val1_out       <= '0;
      ALU_val2_out       <= '0;
      ALU_idx_in_ROB_out <= '0;
    end else begin
      busy_q             <= busy_d;
      pend1_q            <= pend1_d;
      pend2_q            <= pend2_d;
      ALU_flag_out       <= disp_found;
      ALU_op_out         <= disp_found ? op_q[disp_idx]  : '0;
      ALU_val1_out       <= disp_found ? v1_q[disp_idx]  : '0;
      ALU_val2_out       <= disp_found ? v2_q[disp_idx]  : '0;
      ALU_idx_in_ROB_out <= disp_found ? rob_q[disp_idx] : '0;
    end
  end

  // NOTE: payload storage is not reset; busy/pend gate every read, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (rdy && !flush_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (issue_en && issue_idx == IDX_W'(i)) begin
          op_q[i]  <= ISSUE_op_in;
          v1_q[i]  <= iss_v1;
          v2_q[i]  <= iss_v2;
          q1_q[i]  <= ISSUE_Q1_in;
          q2_q[i]  <= ISSUE_Q2_in;
          rob_q[i] <= ISSUE_idx_in_ROB_in;
        end else begin
          if (hit1[i]) v1_q[i] <= res1[i][31:0];
          if (hit2[i]) v2_q[i] <= res2[i][31:0];
        end
      end
    end
  end

endmodule
